// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side (IF and data ports) and RAM-side signals of the unified memory arbiter.
// The arbiter connects through the slave modport; the pipeline/RAM environment uses master.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ready;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port word RAM between the IF and data ports.
// Each access walks IDLE -> ISSUE -> WAIT -> RESP; every output is registered.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int RAM_LAT     = 1,
  parameter int MAX_D_BURST = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  unified_mem_arbiter_if.slave bus,
  output logic                 busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);
  localparam logic [7:0] MAX_B    = 8'(MAX_D_BURST);

  state_e      state_q, state_d;
  logic [2:0]  lat_q, lat_d;
  logic [7:0]  burst_q, burst_d;
  logic        is_data_q, is_data_d;
  logic        we_q, we_d;

  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic if_priority;
  logic grant_d;
  logic grant_i;

  // IF overrides data only once the data port has used up its burst allowance.
  assign if_priority = (MAX_D_BURST != 0) && bus.if_req && bus.d_req && (burst_q == MAX_B);
  assign grant_d     = (state_q == S_IDLE) && bus.d_req && !if_priority;
  assign grant_i     = (state_q == S_IDLE) && bus.if_req && !grant_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      lat_q     <= '0;
      burst_q   <= '0;
      is_data_q <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      burst_q   <= burst_d;
      is_data_q <= is_data_d;
      we_q      <= we_d;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    burst_d   = burst_q;
    is_data_d = is_data_q;
    we_d      = we_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_d || grant_i) begin
          state_d   = S_ISSUE;
          is_data_d = grant_d;
          we_d      = grant_d && bus.d_we;
          if (grant_i) begin
            burst_d = '0;
          end else if (bus.if_req && (burst_q != MAX_B)) begin
            burst_d = burst_q + 8'd1;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        lat_d   = '0;
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_RESP;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values are computed from the state being entered, then registered.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_ISSUE) begin
      ram_en_d    = 1'b1;
      ram_we_d    = we_d;
      ram_addr_d  = grant_d ? bus.d_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
      ram_wdata_d = grant_d ? bus.d_wdata : '0;
    end
    // RESP is entered only from the last WAIT cycle, when ram_rdata is valid.
    if (state_d == S_RESP) begin
      if (is_data_q) begin
        d_ready_d = 1'b1;
        if (!we_q) d_rdata_d = bus.ram_rdata;
      end else begin
        if_ready_d = 1'b1;
        if_rdata_d = bus.ram_rdata;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;

  // Byte-offset bits and address bits above the RAM window are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

endmodule
